piso: RTL and testbench

PISO -- requirements
Module: piso

---
 rtl/piso_pkg.sv | 7 +
 rtl/piso.sv | 38 +++
 tb/tb_piso.sv | 124 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared width constant and bit-count width helper for the PISO shifter.
package piso_pkg;
  localparam int DEFAULT_WIDTH = 10;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/piso.sv
// piso: parallel-in serial-out shifter, MSB (index 0) first, with remaining-bit count.
module piso
  import piso_pkg::*;
#(
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter logic FILL  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [0:WIDTH-1]          parallel_in,
  output logic [0:WIDTH-1]          int_re,
  output logic                      serial_ou,
  output logic                      busy,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);
  localparam int CW = cnt_w(WIDTH);
  logic [0:WIDTH-1] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Shifting continues even when idle, so FILL drains through the register.
  always_comb begin
    sr_d  = load ? parallel_in : {sr_q[1:WIDTH-1], FILL};
    cnt_d = load ? CW'(WIDTH) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign int_re    = sr_q;
  assign bit_cnt   = cnt_q;
  assign serial_ou = sr_q[0];
  assign busy      = cnt_q != '0;
endmodule

// File: tb/tb_piso.sv
// tb_piso: directed self-checking bench for piso at the default width of 10.
module tb_piso;
  logic       clk = 1'b0;
  logic       reset, load;
  logic [0:9] parallel_in, int_re;
  logic       serial_ou, busy;
  logic [3:0] bit_cnt;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  piso dut (
    .clk(clk), .reset(reset), .load(load), .parallel_in(parallel_in),
    .int_re(int_re), .serial_ou(serial_ou), .busy(busy), .bit_cnt(bit_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; parallel_in = '0;
    #2;
    checks++; if ({int_re, serial_ou, busy, bit_cnt} !== 16'h0) $display("FAIL reset_async got int_re=%b ser=%b busy=%b cnt=%0d want all 0", int_re, serial_ou, busy, bit_cnt); else passes++;
    tick;
    checks++; if ({int_re, serial_ou, busy, bit_cnt} !== 16'h0) $display("FAIL reset_held got int_re=%b ser=%b busy=%b cnt=%0d want all 0", int_re, serial_ou, busy, bit_cnt); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_msb_first;
    logic [0:9] pat;
    pat = 10'b0101010101;
    parallel_in = pat; load = 1'b1;
    tick;
    load = 1'b0;
    checks++; if (serial_ou !== 1'b0 || bit_cnt !== 4'd10 || busy !== 1'b1) $display("FAIL load_edge got ser=%b cnt=%0d busy=%b want 0 10 1", serial_ou, bit_cnt, busy); else passes++;
    for (int i = 1; i < 10; i++) begin
      tick;
      checks++; if (serial_ou !== pat[i] || busy !== 1'b1 || bit_cnt !== 4'(10 - i)) $display("FAIL msb_order[%0d] got ser=%b busy=%b cnt=%0d want %b 1 %0d", i, serial_ou, busy, bit_cnt, pat[i], 10 - i); else passes++;
      if (i == 1) begin
        checks++; if (int_re !== 10'b1010101010) $display("FAIL first_shift got %b want 1010101010", int_re); else passes++;
      end
    end
    tick;
    checks++; if (busy !== 1'b0 || bit_cnt !== 4'd0) $display("FAIL busy_fall got busy=%b cnt=%0d want 0 0", busy, bit_cnt); else passes++;
  endtask

  task automatic test_hold_load;
    parallel_in = 10'b1100110011; load = 1'b1;
    tick;
    tick;
    load = 1'b0;
    checks++; if (int_re !== 10'b1100110011 || bit_cnt !== 4'd10 || serial_ou !== 1'b1 || busy !== 1'b1) $display("FAIL hold_load got int_re=%b cnt=%0d ser=%b busy=%b want 1100110011 10 1 1", int_re, bit_cnt, serial_ou, busy); else passes++;
  endtask

  task automatic test_abort;
    parallel_in = 10'b1111111111; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (3) tick;
    checks++; if (int_re !== 10'b1111111000 || bit_cnt !== 4'd7) $display("FAIL abort_mid got int_re=%b cnt=%0d want 1111111000 7", int_re, bit_cnt); else passes++;
    parallel_in = 10'b1100110011; load = 1'b1;
    tick;
    load = 1'b0;
    checks++; if (int_re !== 10'b1100110011 || bit_cnt !== 4'd10 || busy !== 1'b1) $display("FAIL abort_reload got int_re=%b cnt=%0d busy=%b want 1100110011 10 1", int_re, bit_cnt, busy); else passes++;
  endtask

  task automatic test_underflow;
    parallel_in = 10'b1111111111; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (9) tick;
    checks++; if (int_re !== 10'b1000000000 || bit_cnt !== 4'd1 || serial_ou !== 1'b1) $display("FAIL last_bit got int_re=%b cnt=%0d ser=%b want 1000000000 1 1", int_re, bit_cnt, serial_ou); else passes++;
    repeat (3) tick;
    checks++; if (int_re !== 10'b0 || bit_cnt !== 4'd0 || busy !== 1'b0 || serial_ou !== 1'b0) $display("FAIL underflow got int_re=%b cnt=%0d busy=%b ser=%b want 0 0 0 0", int_re, bit_cnt, busy, serial_ou); else passes++;
  endtask

  task automatic test_async_reset;
    parallel_in = 10'b1010011100; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (2) tick;
    #2;
    reset = 1'b1; load = 1'b1;
    #1;
    checks++; if ({int_re, serial_ou, busy, bit_cnt} !== 16'h0) $display("FAIL midword_reset got int_re=%b ser=%b busy=%b cnt=%0d want all 0", int_re, serial_ou, busy, bit_cnt); else passes++;
    tick;
    checks++; if ({int_re, serial_ou, busy, bit_cnt} !== 16'h0) $display("FAIL reset_over_load got int_re=%b busy=%b cnt=%0d want all 0", int_re, busy, bit_cnt); else passes++;
    reset = 1'b0; parallel_in = 10'b0110000001;
    tick;
    load = 1'b0;
    checks++; if (int_re !== 10'b0110000001 || bit_cnt !== 4'd10 || serial_ou !== 1'b0) $display("FAIL post_reset_load got int_re=%b cnt=%0d ser=%b want 0110000001 10 0", int_re, bit_cnt, serial_ou); else passes++;
    tick;
    checks++; if (int_re !== 10'b1100000010 || bit_cnt !== 4'd9 || serial_ou !== 1'b1) $display("FAIL post_reset_shift got int_re=%b cnt=%0d ser=%b want 1100000010 9 1", int_re, bit_cnt, serial_ou); else passes++;
  endtask

  task automatic test_pin_ignore;
    logic [0:9] exp;
    exp = 10'b1011001110;
    parallel_in = exp; load = 1'b1;
    tick;
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      parallel_in = 10'($urandom);
      tick;
      exp = {exp[1:9], 1'b0};
      checks++; if (int_re !== exp) $display("FAIL pin_ignore[%0d] got %b want %b", i, int_re, exp); else passes++;
    end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_hold_load;
    test_abort;
    test_underflow;
    test_async_reset;
    test_pin_ignore;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
